dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port 256x16 data memory between the processor datapath (port C) and a host loader/debug port (port H).
- Sits between the Datapath data-memory interface, the host interface and the data-memory RAM.
- Uses a req/gnt/rvalid handshake, round-robin fairness and an optional host burst lock.
- Serialises all memory accesses through a 3-state FSM.

---
 rtl/dmem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Purpose:
//   Shares one single-port synchronous data RAM between two requesters. The
//   processor datapath uses port C and the host loader/debug path uses port H.
//   A 3-state FSM (IDLE -> ACC -> RESP) carries out one access at a time.
//   Each access takes one ACC cycle and one RESP cycle, so a new access can
//   start at most every 2 cycles.
//
// Handshake (both ports):
//   - The requester raises req and holds req, wr, addr and wdata stable until
//     the cycle in which gnt is high.
//   - gnt is a one-cycle pulse in the ACC cycle. The operands are captured
//     when the winner is selected, so the requester may change them from the
//     gnt cycle onward.
//   - For a read, rvalid is a one-cycle pulse in the following RESP cycle,
//     with rdata valid in that cycle. rdata then keeps that value until the
//     same port's next read.
//   - A write never produces rvalid.
//   - If req is still high (or raised again) in the gnt cycle, the port takes
//     part in the next selection.
//
// Arbitration:
//   - A single requester always wins.
//   - On a tie, the port that did not win last time wins (last_win resets to H,
//     so the CPU wins the first tie after reset).
//   - While h_lock is high and the host won last time, any host request wins.
//
// Optional feature (macro DMEM_ARB_STATS_EN):
//   When defined, c_wait_cnt counts the cycles in which c_req=1 and c_gnt=0.
//   The counter saturates at 16'hFFFF and is cleared only by Reset.
//   When undefined, c_wait_cnt is tied to 0.
//
// Ports:
//   Clk, Reset                    rising-edge clock, async active-high reset
//   c_req/c_wr/c_addr/c_wdata     CPU request and operands
//   c_gnt/c_rvalid/c_rdata        CPU grant pulse, read-valid pulse, read data
//   h_req/h_wr/h_addr/h_wdata     host request and operands
//   h_lock                        host burst lock
//   h_gnt/h_rvalid/h_rdata        host grant pulse, read-valid pulse, read data
//   mem_en/mem_wr/mem_addr/mem_wdata  RAM control (active only in ACC)
//   mem_rdata                     RAM read data, valid 1 cycle after mem_en
//   busy                          FSM not in IDLE
//   state_out                     FSM state: IDLE=0, ACC=1, RESP=2
//   c_wait_cnt                    CPU stall counter (optional)

module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          c_req,
    input  logic          c_wr,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          h_req,
    input  logic          h_wr,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    input  logic          h_lock,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    state_out,
    output logic [15:0]   c_wait_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Port encoding used for lat_win / last_win: 0 = CPU, 1 = host.
    state_t          state, state_nxt;
    logic            last_win;
    logic            lat_win;
    logic            lat_wr;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic [DW-1:0]   c_rdata_q;
    logic [DW-1:0]   h_rdata_q;

    logic            any_req;
    logic            sel_h;
    logic            load;
    logic            in_acc;
    logic            rd_resp;

    assign any_req = c_req | h_req;

    // The host wins in three cases:
    //   - it is the only requester;
    //   - the CPU won last time (round-robin);
    //   - h_lock is high. This only matters when last_win is H, because when
    //     last_win is C the host already wins by round-robin.
    assign sel_h = h_req & (~c_req | ~last_win | h_lock);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load      = 1'b1;
                    state_nxt = ACC;
                end
            end
            ACC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (any_req) begin
                    load      = 1'b1;
                    state_nxt = ACC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The RAM outputs are decoded from the state. An asynchronous reset during
    // ACC therefore drops mem_en/mem_wr at once, before the RAM edge can
    // commit the write.
    assign in_acc    = (state == ACC);
    assign rd_resp   = (state == RESP) & ~lat_wr;

    assign mem_en    = in_acc;
    assign mem_wr    = in_acc & lat_wr;
    assign mem_addr  = in_acc ? lat_addr  : '0;
    assign mem_wdata = in_acc ? lat_wdata : '0;

    assign c_gnt     = in_acc & ~lat_win;
    assign h_gnt     = in_acc &  lat_win;
    assign c_rvalid  = rd_resp & ~lat_win;
    assign h_rvalid  = rd_resp &  lat_win;

    // During RESP the RAM output passes straight through. After that, the
    // captured copy keeps the value until the port's next read.
    assign c_rdata   = c_rvalid ? mem_rdata : c_rdata_q;
    assign h_rdata   = h_rvalid ? mem_rdata : h_rdata_q;

    assign busy      = (state != IDLE);
    assign state_out = state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            last_win  <= 1'b1;
            lat_win   <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            c_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                lat_win   <= sel_h;
                lat_wr    <= sel_h ? h_wr    : c_wr;
                lat_addr  <= sel_h ? h_addr  : c_addr;
                lat_wdata <= sel_h ? h_wdata : c_wdata;
            end
            if (in_acc) begin
                last_win <= lat_win;
            end
            if (c_rvalid) begin
                c_rdata_q <= mem_rdata;
            end
            if (h_rvalid) begin
                h_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] wait_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wait_q <= '0;
        end else if (c_req && !c_gnt && (wait_q != 16'hFFFF)) begin
            wait_q <= wait_q + 16'd1;
        end
    end

    assign c_wait_cnt = wait_q;
`else
    assign c_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//
// Purpose:
//   Self-checking bench for dmem_arbiter.
//   - A behavioural 256x16 synchronous RAM is connected to the arbiter.
//   - A shadow copy of memory (model_mem) gives the expected read data.
//   - Expected read data is pushed to a per-port queue when a read is driven,
//     and popped and compared when that port's rvalid pulses.
//   - The order and cycle of each grant are logged and checked against the
//     round-robin and lock rules.

module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          c_req, c_wr, c_gnt, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          h_req, h_wr, h_lock, h_gnt, h_rvalid;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata, h_rdata;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic [1:0]    state_out;
    logic [15:0]   c_wait_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    logic [DW-1:0] c_exp_q[$];
    logic [DW-1:0] h_exp_q[$];
    int            gnt_port_q[$];
    int            gnt_cyc_q[$];
    logic [DW-1:0] model_mem[256];

    // RAM
    logic [DW-1:0] ram[256];
    bit            ram_vld[256];

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .Clk(Clk), .Reset(Reset),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_lock(h_lock),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .state_out(state_out), .c_wait_cnt(c_wait_cnt)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // Power-up contents of a location that has not been written yet.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    always @(posedge Clk) begin
        if (mem_en) begin
            if (mem_wr) begin
                ram[mem_addr]     <= mem_wdata;
                ram_vld[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_vld[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard / monitor on the falling edge.
    always @(negedge Clk) begin
        cycle++;
        if (!Reset) begin
            if (c_gnt || h_gnt) begin
                check("gnt_onehot", {31'd0, c_gnt & h_gnt}, 32'd0);
                gnt_port_q.push_back(h_gnt ? 1 : 0);
                gnt_cyc_q.push_back(cycle);
            end
            if (c_rvalid || h_rvalid) begin
                check("rvalid_onehot", {31'd0, c_rvalid & h_rvalid}, 32'd0);
            end
            if (c_rvalid) begin
                if (c_exp_q.size() == 0) check("c_rvalid_unexpected", 32'd1, 32'd0);
                else check("c_rdata", {16'd0, c_rdata}, {16'd0, c_exp_q.pop_front()});
            end
            if (h_rvalid) begin
                if (h_exp_q.size() == 0) check("h_rvalid_unexpected", 32'd1, 32'd0);
                else check("h_rdata", {16'd0, h_rdata}, {16'd0, h_exp_q.pop_front()});
            end
        end
    end

    // ---------------- drivers ----------------
    // Each driver is called at a falling edge.
    // - req stays high for all n accesses.
    // - The next operands are driven in the gnt cycle of the previous access.
    task automatic cpu_burst(input int n, input logic wr, input logic [AW-1:0] base,
                             input logic [DW-1:0] wbase);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            d = wbase + DW'(i);
            c_wr = wr; c_addr = a; c_wdata = d; c_req = 1'b1;
            if (wr) model_mem[a] = d;
            else c_exp_q.push_back(model_mem[a]);
            for (int k = 0; k < 50; k++) begin
                @(negedge Clk);
                if (c_gnt) break;
            end
            if (!c_gnt) check("c_gnt_timeout", 32'd0, 32'd1);
        end
        c_req = 1'b0;
    endtask

    task automatic host_burst(input int n, input logic wr, input logic [AW-1:0] base,
                              input logic [DW-1:0] wbase);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            d = wbase + DW'(i);
            h_wr = wr; h_addr = a; h_wdata = d; h_req = 1'b1;
            if (wr) model_mem[a] = d;
            else h_exp_q.push_back(model_mem[a]);
            for (int k = 0; k < 50; k++) begin
                @(negedge Clk);
                if (h_gnt) break;
            end
            if (!h_gnt) check("h_gnt_timeout", 32'd0, 32'd1);
        end
        h_req = 1'b0;
    endtask

    task automatic check_order(input string tag, input int exp_ports[]);
        check({tag, "_count"}, gnt_port_q.size(), exp_ports.size());
        for (int i = 0; i < exp_ports.size() && i < gnt_port_q.size(); i++)
            check({tag, "_port"}, gnt_port_q[i], exp_ports[i]);
    endtask

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        Reset = 1'b1;
        c_req = 0; c_wr = 0; c_addr = '0; c_wdata = '0;
        h_req = 0; h_wr = 0; h_addr = '0; h_wdata = '0; h_lock = 0;
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(AW'(i));

        // Reset state
        repeat (2) @(negedge Clk);
        check("rst_state", state_out, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_gnt", {c_gnt, h_gnt}, 0);
        check("rst_rvalid", {c_rvalid, h_rvalid}, 0);
        check("rst_rdata", {c_rdata, h_rdata}, 0);
        check("rst_wait_cnt", c_wait_cnt, 0);
        Reset = 1'b0;

        // Idle: no requests for 10 cycles
        repeat (10) begin
            @(negedge Clk);
            check("idle_state", state_out, 0);
            check("idle_mem_en", mem_en, 0);
            check("idle_gnt_rvalid", {c_gnt, h_gnt, c_rvalid, h_rvalid}, 0);
        end

        // Contention: both ports read and hold req.
        // Expected grant order C, H, C, H, one grant every 2 cycles.
        gnt_port_q.delete(); gnt_cyc_q.delete();
        fork
            cpu_burst(2, 1'b0, 8'h01, 16'h0000);
            host_burst(2, 1'b0, 8'h02, 16'h0000);
        join
        repeat (3) @(negedge Clk);
        check_order("contention", '{0, 1, 0, 1});
        for (int i = 0; i + 1 < gnt_cyc_q.size(); i++)
            check("contention_spacing", gnt_cyc_q[i+1] - gnt_cyc_q[i], 2);

        // CPU write of 16'hABCD to 8'h10
        c_req = 1; c_wr = 1; c_addr = 8'h10; c_wdata = 16'hABCD;
        model_mem[8'h10] = 16'hABCD;
        @(negedge Clk);
        check("wr_gnt", c_gnt, 1);
        check("wr_mem_en", mem_en, 1);
        check("wr_mem_wr", mem_wr, 1);
        check("wr_mem_addr", mem_addr, 8'h10);
        check("wr_mem_wdata", mem_wdata, 16'hABCD);
        check("wr_state_acc", state_out, 1);
        c_req = 0;
        @(negedge Clk);
        check("wr_no_rvalid", c_rvalid, 0);
        check("wr_state_resp", state_out, 2);
        @(negedge Clk);

        // CPU read of 8'h10: gnt after 1 cycle, rvalid after 2 cycles
        c_req = 1; c_wr = 0; c_addr = 8'h10;
        c_exp_q.push_back(model_mem[8'h10]);
        @(negedge Clk);
        check("rd_gnt", c_gnt, 1);
        check("rd_mem_wr", mem_wr, 0);
        c_req = 0;
        @(negedge Clk);
        check("rd_rvalid", c_rvalid, 1);
        @(negedge Clk);
        check("rd_rdata_held", c_rdata, 16'hABCD);
        check("rd_rvalid_pulse", c_rvalid, 0);

        // Host lock: 4 host writes to 8'h20..8'h23 finish before the CPU is granted
        gnt_port_q.delete(); gnt_cyc_q.delete();
        h_lock = 1'b1;
        fork
            host_burst(4, 1'b1, 8'h20, 16'hC0DE);
            cpu_burst(1, 1'b0, 8'h10, 16'h0000);
        join
        h_lock = 1'b0;
        repeat (2) @(negedge Clk);
        check_order("lock", '{1, 1, 1, 1, 0});
`ifdef DMEM_ARB_STATS_EN
        check("lock_wait_cnt_ge8", {31'd0, c_wait_cnt >= 16'd8}, 32'd1);
`else
        check("lock_wait_cnt_zero", c_wait_cnt, 0);
`endif
        // Read the host writes back. The host reads must not change c_rdata.
        host_burst(4, 1'b0, 8'h20, 16'h0000);
        repeat (2) @(negedge Clk);
        check("c_rdata_untouched", c_rdata, 16'hABCD);

        // Reset during the ACC cycle of a write
        cpu_burst(1, 1'b1, 8'h30, 16'h1234);
        repeat (2) @(negedge Clk);
        c_req = 1; c_wr = 1; c_addr = 8'h30; c_wdata = 16'h5555;
        @(posedge Clk);
        #2;
        check("mid_acc_mem_en", mem_en, 1);
        Reset = 1'b1;
        #1;
        check("mid_rst_mem_en", mem_en, 0);
        check("mid_rst_mem_wr", mem_wr, 0);
        check("mid_rst_state", state_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_gnt", c_gnt, 0);
        c_req = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        cpu_burst(1, 1'b0, 8'h30, 16'h0000);
        repeat (3) @(negedge Clk);

        check("c_queue_empty", c_exp_q.size(), 0);
        check("h_queue_empty", h_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
